// File: rtl/mul_div_unit.sv
// mul_div_unit
//   Iterative multiply/divide unit holding the architectural HI/LO registers.
//   It runs MULT, MULTU, DIV and DIVU one bit per cycle and services MTHI/MTLO
//   writes. Latency is WIDTH+1 cycles: WIDTH CALC iterations, then one FIX
//   cycle that applies the sign correction and writes HI/LO.
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   start   in   launch an operation (accepted only in IDLE)
//   op      in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a   in   multiplicand / dividend
//   src_b   in   multiplier / divisor
//   mthi    in   write wdata to HI (accepted only in IDLE)
//   mtlo    in   write wdata to LO (accepted only in IDLE)
//   wdata   in   data for MTHI/MTLO
//   cancel  in   flush: abort any operation, highest priority input
//   busy    out  operation in flight
//   done    out  one-cycle pulse after HI/LO were written by an operation
//   hi, lo  out  architectural HI/LO registers
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [CW-1:0]      count_reg;
    logic               is_div_reg;
    logic               neg_q_reg;      // negate product / quotient in FIX
    logic               neg_r_reg;      // negate remainder in FIX
    logic [WIDTH-1:0]   raw_a_reg;      // raw dividend, returned in HI on divide-by-zero
    logic [WIDTH-1:0]   mag_a_reg;
    logic [WIDTH-1:0]   mag_b_reg;
    // Multiply: {partial sum, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [2*WIDTH-1:0] acc_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    // Operand magnitudes and signs for the operation being launched.
    logic             is_signed;
    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        is_signed = ~op[0];
        sign_a    = is_signed & src_a[WIDTH-1];
        sign_b    = is_signed & src_b[WIDTH-1];
        mag_a     = sign_a ? (~src_a + 1'b1) : src_a;
        mag_b     = sign_b ? (~src_b + 1'b1) : src_b;
    end

    // One iteration of shift-add multiply or restoring divide.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        mul_sum   = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                  + (acc_reg[0] ? {1'b0, mag_a_reg} : {(WIDTH+1){1'b0}});
        div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b_reg};
        div_ge    = (div_shift >= {1'b0, mag_b_reg});
        if (is_div_reg) begin
            acc_step = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                        acc_reg[WIDTH-2:0], div_ge};
        end else begin
            acc_step = {mul_sum, acc_reg[WIDTH-1:1]};
        end
    end

    // Sign-corrected results used in FIX.
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        product_fix = neg_q_reg ? (~acc_reg + 1'b1) : acc_reg;
        quot_fix    = neg_q_reg ? (~acc_reg[WIDTH-1:0] + 1'b1) : acc_reg[WIDTH-1:0];
        rem_fix     = neg_r_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1)
                                : acc_reg[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            is_div_reg <= 1'b0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            raw_a_reg  <= '0;
            mag_a_reg  <= '0;
            mag_b_reg  <= '0;
            acc_reg    <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            if (cancel) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (mthi) hi_reg <= wdata;
                        if (mtlo) lo_reg <= wdata;
                        if (start) begin
                            state_reg  <= CALC;
                            busy_reg   <= 1'b1;
                            count_reg  <= '0;
                            is_div_reg <= op[1];
                            neg_q_reg  <= sign_a ^ sign_b;
                            neg_r_reg  <= sign_a;
                            raw_a_reg  <= src_a;
                            mag_a_reg  <= mag_a;
                            mag_b_reg  <= mag_b;
                            // Multiplier bits or dividend bits start in the low half.
                            acc_reg    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                        end
                    end
                    CALC: begin
                        acc_reg   <= acc_step;
                        count_reg <= count_reg + 1'b1;
                        if (count_reg == LAST_ITER) state_reg <= FIX;
                    end
                    FIX: begin
                        if (!is_div_reg) begin
                            hi_reg <= product_fix[2*WIDTH-1:WIDTH];
                            lo_reg <= product_fix[WIDTH-1:0];
                        end else if (mag_b_reg == '0) begin
                            hi_reg <= raw_a_reg;
                            lo_reg <= {WIDTH{1'b1}};
                        end else begin
                            hi_reg <= rem_fix;
                            lo_reg <= quot_fix;
                        end
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign hi   = hi_reg;
    assign lo   = lo_reg;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed corner cases plus randomized operations
// checked against an arithmetic reference model.
module tb_mul_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    mul_div_unit #(.WIDTH(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .wdata  (wdata),
        .cancel (cancel),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one clock; outputs are then sampled 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit / signed integer arithmetic.
    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (o)
            2'b00: begin
                p  = 64'(longint'(sa) * longint'(sb));
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                p  = {32'b0, a} * {32'b0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else if (o == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000;
                    eh = 32'd0;
                end else if (o == 2'b10) begin
                    el = 32'(sa / sb);
                    eh = 32'(sa % sb);
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endtask

    // Launch an operation and wait for completion, checking latency and result.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] eh, el;
        int cyc;
        model(o, a, b, eh, el);
        start = 1'b1; op = o; src_a = a; src_b = b;
        tick();
        start = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        check("busy_cycles", 32'(cyc), 32'd33);
        check("done_high", 32'(done), 32'd1);
        check("result_hi", hi, eh);
        check("result_lo", lo, el);
        $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h (exp hi=%h lo=%h)", o, a, b, hi, lo, eh, el);
        tick();
        check("done_pulse_end", 32'(done), 32'd0);
    endtask

    initial begin
        logic [31:0] eh, el, hold_hi, hold_lo;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int cyc;

        reset = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        mthi = 1'b0; mtlo = 1'b0; wdata = '0; cancel = 1'b0;
        tick();
        tick();
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        reset = 1'b1;
        tick();

        // Directed arithmetic corners
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        run_op(2'b00, -32'sd3, 32'd7);
        run_op(2'b10, -32'sd7, 32'd2);
        run_op(2'b11, 32'd100, 32'd0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000);

        // MTHI in IDLE
        mthi = 1'b1; wdata = 32'h1234;
        tick();
        mthi = 1'b0;
        check("mthi_hi", hi, 32'h1234);
        $display("[TB] mthi 0x1234 -> hi=%h", hi);

        // MTHI+MTLO together
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hA5A5_5A5A;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo_hi", hi, 32'hA5A5_5A5A);
        check("mthilo_lo", lo, 32'hA5A5_5A5A);
        $display("[TB] mthi+mtlo -> hi=%h lo=%h", hi, lo);

        // MTLO during busy is ignored, result lands later
        model(2'b01, 32'd11, 32'd13, eh, el);
        hold_lo = lo;
        start = 1'b1; op = 2'b01; src_a = 32'd11; src_b = 32'd13;
        tick();
        start = 1'b0;
        tick(); tick();
        mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
        tick();
        mtlo = 1'b0;
        check("mtlo_busy_lo", lo, hold_lo);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin cyc++; tick(); end
        check("mtlo_busy_result_lo", lo, el);
        check("mtlo_busy_result_hi", hi, eh);
        $display("[TB] mtlo during busy -> lo=%h", lo);
        tick();

        // MTHI/MTLO with start in the same cycle: both accepted, result overwrites
        model(2'b11, 32'd1000, 32'd7, eh, el);
        start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd7;
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0BAD_F00D;
        tick();
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        check("mt_start_hi", hi, 32'h0BAD_F00D);
        check("mt_start_lo", lo, 32'h0BAD_F00D);
        check("mt_start_busy", 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 100) begin cyc++; tick(); end
        check("mt_start_res_hi", hi, eh);
        check("mt_start_res_lo", lo, el);
        $display("[TB] mt+start divu 1000/7 -> hi=%h lo=%h", hi, lo);
        tick();

        // MULTU 5*6, second start at cycle 10 ignored, cancel at cycle 20
        hold_hi = hi; hold_lo = lo;
        start = 1'b1; op = 2'b01; src_a = 32'd5; src_b = 32'd6;
        tick();
        start = 1'b0;
        for (int i = 1; i < 20; i++) begin
            if (i == 10) begin
                start = 1'b1; op = 2'b11; src_a = 32'd77; src_b = 32'd3;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check("pre_cancel_busy", 32'(busy), 32'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy", 32'(busy), 32'd0);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) cyc++;
            tick();
        end
        check("cancel_no_done", 32'(cyc), 32'd0);
        check("cancel_hi", hi, hold_hi);
        check("cancel_lo", lo, hold_lo);
        $display("[TB] cancel mid-op -> busy=%b hi=%h lo=%h", busy, hi, lo);

        // cancel together with start in IDLE drops the start
        start = 1'b1; cancel = 1'b1; op = 2'b01; src_a = 32'd2; src_b = 32'd2;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("cancel_start_busy", 32'(busy), 32'd0);
        tick();
        check("cancel_start_done", 32'(done), 32'd0);
        $display("[TB] cancel+start -> busy=%b", busy);

        // Reset during DIV
        start = 1'b1; op = 2'b10; src_a = 32'd500; src_b = 32'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        #2;
        reset = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_hi", hi, 32'd0);
        check("midreset_lo", lo, 32'd0);
        $display("[TB] reset mid-div -> busy=%b hi=%h lo=%h", busy, hi, lo);
        tick();
        reset = 1'b1;
        tick();
        run_op(2'b11, 32'd9, 32'd4);
        check("post_reset_lo", lo, 32'd2);
        check("post_reset_hi", hi, 32'd1);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_op(rop, ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
